// File: rtl/cpu_defs.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cpu_defs : shared fetch-path constants and redirect source encoding   |
// | rev 1.0                                                               |
// +----------------------------------------------------------------------+
package cpu_defs;

  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'h0000_0180;
  localparam logic [31:0] RESET_PC_DEFAULT   = 32'h0000_0000;
  localparam logic [31:0] PC_STEP            = 32'd4;

  // Encoding order is the redirect priority order, so sources compare with '>'.
  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_BR   = 2'd1,
    SRC_ERET = 2'd2,
    SRC_EXC  = 2'd3
  } redir_src_e;

endpackage
`default_nettype wire

// File: rtl/pc_redirect_arb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pc_redirect_arb : fixed-priority next-PC mux with alignment checking  |
// | rev 1.0                                                               |
// +----------------------------------------------------------------------+
module pc_redirect_arb
  import cpu_defs::*;
#(
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT
) (
  input  logic [31:0] pc_cur,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        exc_req,
  input  logic        eret_req,
  input  logic [31:0] epc,
  input  logic        pend_vld,
  input  logic [31:0] pend_pc,
  output logic [31:0] pc_sel,
  output redir_src_e  redir_src,
  output logic        adel,
  output logic [31:0] adel_addr
);

  logic eret_ok;
  logic br_ok;

  assign eret_ok = (epc[1:0] == 2'b00);
  assign br_ok   = (br_target[1:0] == 2'b00);

  always_comb begin
    pc_sel    = pc_cur + PC_STEP;
    redir_src = SRC_NONE;
    adel      = 1'b0;
    adel_addr = 32'h0000_0000;

    if (exc_req) begin
      pc_sel    = EXC_VECTOR;
      redir_src = SRC_EXC;
    end else begin
      if (eret_req && eret_ok) begin
        pc_sel    = epc;
        redir_src = SRC_ERET;
      end else if (br_taken && br_ok) begin
        pc_sel    = br_target;
        redir_src = SRC_BR;
      end else if (pend_vld) begin
        pc_sel    = pend_pc;
      end

      // A misaligned ERET shadows any branch; a branch only faults if it would have won.
      if (eret_req && !eret_ok) begin
        adel      = 1'b1;
        adel_addr = epc;
      end else if (!eret_req && br_taken && !br_ok) begin
        adel      = 1'b1;
        adel_addr = br_target;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/pc_next_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pc_next_gen : next fetch PC with stall-held redirect and ADEL capture |
// | rev 1.0                                                               |
// +----------------------------------------------------------------------+
module pc_next_gen
  import cpu_defs::*;
#(
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT,
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        stall,
  input  logic [31:0] pc_cur,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        exc_req,
  input  logic        eret_req,
  input  logic [31:0] epc,
  output logic [31:0] pc_next,
  output logic        redirect_pending,
  output logic        fetch_adel,
  output logic [31:0] bad_vaddr
);

  logic        pend_vld_q, pend_vld_d;
  logic [31:0] pend_pc_q,  pend_pc_d;
  redir_src_e  pend_src_q, pend_src_d;
  logic        adel_q,     adel_d;
  logic [31:0] bad_vaddr_q, bad_vaddr_d;

  logic [31:0] pc_sel;
  redir_src_e  redir_src;
  logic        adel;
  logic [31:0] adel_addr;

  pc_redirect_arb #(
    .EXC_VECTOR (EXC_VECTOR)
  ) u_arb (
    .pc_cur    (pc_cur),
    .br_taken  (br_taken),
    .br_target (br_target),
    .exc_req   (exc_req),
    .eret_req  (eret_req),
    .epc       (epc),
    .pend_vld  (pend_vld_q),
    .pend_pc   (pend_pc_q),
    .pc_sel    (pc_sel),
    .redir_src (redir_src),
    .adel      (adel),
    .adel_addr (adel_addr)
  );

  always_comb begin
    pend_vld_d  = pend_vld_q;
    pend_pc_d   = pend_pc_q;
    pend_src_d  = pend_src_q;
    adel_d      = adel;
    bad_vaddr_d = adel ? adel_addr : bad_vaddr_q;

    if (!stall) begin
      // Held target is on pc_next this cycle and fetch loads it at this edge.
      pend_vld_d = 1'b0;
    end else if (redir_src != SRC_NONE && (!pend_vld_q || redir_src > pend_src_q)) begin
      pend_vld_d = 1'b1;
      pend_pc_d  = pc_sel;
      pend_src_d = redir_src;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pend_vld_q  <= 1'b0;
      pend_pc_q   <= 32'h0000_0000;
      pend_src_q  <= SRC_NONE;
      adel_q      <= 1'b0;
      bad_vaddr_q <= 32'h0000_0000;
    end else begin
      pend_vld_q  <= pend_vld_d;
      pend_pc_q   <= pend_pc_d;
      pend_src_q  <= pend_src_d;
      adel_q      <= adel_d;
      bad_vaddr_q <= bad_vaddr_d;
    end
  end

  assign pc_next          = rstn ? pc_sel : RESET_PC;
  assign redirect_pending = pend_vld_q;
  assign fetch_adel       = adel_q;
  assign bad_vaddr        = bad_vaddr_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_next_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pc_next_gen : directed self-checking bench for pc_next_gen         |
// | rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_pc_next_gen;

  logic        clk = 1'b0;
  logic        rstn;
  logic        stall;
  logic [31:0] pc_cur;
  logic        br_taken;
  logic [31:0] br_target;
  logic        exc_req;
  logic        eret_req;
  logic [31:0] epc;
  logic [31:0] pc_next;
  logic        redirect_pending;
  logic        fetch_adel;
  logic [31:0] bad_vaddr;

  int checks = 0;
  int errors = 0;

  pc_next_gen dut (
    .clk              (clk),
    .rstn             (rstn),
    .stall            (stall),
    .pc_cur           (pc_cur),
    .br_taken         (br_taken),
    .br_target        (br_target),
    .exc_req          (exc_req),
    .eret_req         (eret_req),
    .epc              (epc),
    .pc_next          (pc_next),
    .redirect_pending (redirect_pending),
    .fetch_adel       (fetch_adel),
    .bad_vaddr        (bad_vaddr)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_req();
    stall     = 1'b0;
    br_taken  = 1'b0;
    br_target = 32'h0;
    exc_req   = 1'b0;
    eret_req  = 1'b0;
    epc       = 32'h0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    clear_req();
    pc_cur    = 32'h0000_0040;
    br_taken  = 1'b1;
    br_target = 32'h0000_0100;
    tick();
    tick();
    checks++; if (pc_next !== 32'h0) begin errors++;
      $display("FAIL reset_pc_next: got %h expected %h", pc_next, 32'h0); end
    checks++; if (redirect_pending !== 1'b0) begin errors++;
      $display("FAIL reset_pending: got %b expected 0", redirect_pending); end
    checks++; if (fetch_adel !== 1'b0) begin errors++;
      $display("FAIL reset_adel: got %b expected 0", fetch_adel); end
    checks++; if (bad_vaddr !== 32'h0) begin errors++;
      $display("FAIL reset_bad_vaddr: got %h expected 0", bad_vaddr); end
    clear_req();
    #2 rstn = 1'b1;
    tick();
  endtask

  task automatic test_sequential();
    pc_cur = 32'h0000_0010;
    #1;
    checks++; if (pc_next !== 32'h0000_0014) begin errors++;
      $display("FAIL seq_inc: got %h expected %h", pc_next, 32'h0000_0014); end
    pc_cur = 32'hFFFF_FFFC;
    #1;
    checks++; if (pc_next !== 32'h0000_0000) begin errors++;
      $display("FAIL seq_wrap: got %h expected %h", pc_next, 32'h0); end
    tick();
  endtask

  task automatic test_branch();
    pc_cur    = 32'h0000_0020;
    br_taken  = 1'b1;
    br_target = 32'h0000_0100;
    #1;
    checks++; if (pc_next !== 32'h0000_0100) begin errors++;
      $display("FAIL br_pc_next: got %h expected %h", pc_next, 32'h0000_0100); end
    tick();
    clear_req();
    #1;
    checks++; if (redirect_pending !== 1'b0) begin errors++;
      $display("FAIL br_no_pending: got %b expected 0", redirect_pending); end
    epc      = 32'h0000_0040;
    eret_req = 1'b1;
    #1;
    checks++; if (pc_next !== 32'h0000_0040) begin errors++;
      $display("FAIL eret_pc_next: got %h expected %h", pc_next, 32'h0000_0040); end
    tick();
    clear_req();
  endtask

  task automatic test_stall_branch();
    pc_cur    = 32'h0000_0030;
    stall     = 1'b1;
    br_taken  = 1'b1;
    br_target = 32'h0000_0200;
    tick();
    br_taken  = 1'b0;
    br_target = 32'h0;
    #1;
    checks++; if (redirect_pending !== 1'b1) begin errors++;
      $display("FAIL stall_pend_c1: got %b expected 1", redirect_pending); end
    tick();
    checks++; if (redirect_pending !== 1'b1) begin errors++;
      $display("FAIL stall_pend_c2: got %b expected 1", redirect_pending); end
    tick();
    stall = 1'b0;
    #1;
    checks++; if (redirect_pending !== 1'b1) begin errors++;
      $display("FAIL stall_pend_c3: got %b expected 1", redirect_pending); end
    checks++; if (pc_next !== 32'h0000_0200) begin errors++;
      $display("FAIL stall_release_pc: got %h expected %h", pc_next, 32'h0000_0200); end
    tick();
    checks++; if (redirect_pending !== 1'b0) begin errors++;
      $display("FAIL stall_pend_clear: got %b expected 0", redirect_pending); end
    checks++; if (pc_next !== 32'h0000_0034) begin errors++;
      $display("FAIL stall_after_pc: got %h expected %h", pc_next, 32'h0000_0034); end
  endtask

  task automatic test_priority();
    pc_cur    = 32'h0000_0050;
    stall     = 1'b1;
    br_taken  = 1'b1;
    br_target = 32'h0000_0300;
    tick();
    stall     = 1'b0;
    exc_req   = 1'b1;
    eret_req  = 1'b1;
    epc       = 32'h0000_0040;
    br_target = 32'h0000_0100;
    #1;
    checks++; if (pc_next !== 32'h0000_0180) begin errors++;
      $display("FAIL prio_pc: got %h expected %h", pc_next, 32'h0000_0180); end
    tick();
    clear_req();
    #1;
    checks++; if (redirect_pending !== 1'b0) begin errors++;
      $display("FAIL prio_flush: got %b expected 0", redirect_pending); end
    // held branch overwritten by exception, then a later branch is dropped
    stall     = 1'b1;
    br_taken  = 1'b1;
    br_target = 32'h0000_0300;
    tick();
    br_taken  = 1'b0;
    exc_req   = 1'b1;
    tick();
    exc_req   = 1'b0;
    br_taken  = 1'b1;
    br_target = 32'h0000_0400;
    tick();
    clear_req();
    #1;
    checks++; if (pc_next !== 32'h0000_0180) begin errors++;
      $display("FAIL prio_exc_held: got %h expected %h", pc_next, 32'h0000_0180); end
    tick();
  endtask

  task automatic test_misaligned();
    pc_cur    = 32'h0000_0020;
    br_taken  = 1'b1;
    br_target = 32'h0000_0102;
    #1;
    checks++; if (pc_next !== 32'h0000_0024) begin errors++;
      $display("FAIL mis_pc: got %h expected %h", pc_next, 32'h0000_0024); end
    tick();
    clear_req();
    #1;
    checks++; if (fetch_adel !== 1'b1) begin errors++;
      $display("FAIL mis_adel: got %b expected 1", fetch_adel); end
    checks++; if (bad_vaddr !== 32'h0000_0102) begin errors++;
      $display("FAIL mis_vaddr: got %h expected %h", bad_vaddr, 32'h0000_0102); end
    tick();
    checks++; if (fetch_adel !== 1'b0) begin errors++;
      $display("FAIL mis_adel_clear: got %b expected 0", fetch_adel); end
    checks++; if (bad_vaddr !== 32'h0000_0102) begin errors++;
      $display("FAIL mis_vaddr_hold: got %h expected %h", bad_vaddr, 32'h0000_0102); end
    // misaligned ERET under stall is flagged but never captured
    stall    = 1'b1;
    eret_req = 1'b1;
    epc      = 32'h0000_0041;
    tick();
    clear_req();
    #1;
    checks++; if (redirect_pending !== 1'b0) begin errors++;
      $display("FAIL mis_eret_nocap: got %b expected 0", redirect_pending); end
    checks++; if (bad_vaddr !== 32'h0000_0041) begin errors++;
      $display("FAIL mis_eret_vaddr: got %h expected %h", bad_vaddr, 32'h0000_0041); end
    checks++; if (pc_next !== 32'h0000_0024) begin errors++;
      $display("FAIL mis_eret_pc: got %h expected %h", pc_next, 32'h0000_0024); end
  endtask

  task automatic test_reset_mid();
    pc_cur    = 32'h0000_0060;
    stall     = 1'b1;
    br_taken  = 1'b1;
    br_target = 32'h0000_0500;
    tick();
    br_taken  = 1'b0;
    #1;
    checks++; if (redirect_pending !== 1'b1) begin errors++;
      $display("FAIL rstmid_setup: got %b expected 1", redirect_pending); end
    #1 rstn = 1'b0;
    #1;
    checks++; if (redirect_pending !== 1'b0) begin errors++;
      $display("FAIL rstmid_pending: got %b expected 0", redirect_pending); end
    checks++; if (pc_next !== 32'h0000_0000) begin errors++;
      $display("FAIL rstmid_pc: got %h expected %h", pc_next, 32'h0); end
    checks++; if (bad_vaddr !== 32'h0000_0000) begin errors++;
      $display("FAIL rstmid_vaddr: got %h expected 0", bad_vaddr); end
    tick();
    stall = 1'b0;
    #2 rstn = 1'b1;
    #1;
    checks++; if (pc_next !== 32'h0000_0064) begin errors++;
      $display("FAIL rstmid_release_pc: got %h expected %h", pc_next, 32'h0000_0064); end
    tick();
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_stall_branch();
    test_priority();
    test_misaligned();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
